num_ram_loader: RTL and testbench
=================================

Name: num_ram_loader

Overview:
Writer-side counterpart to the 24-bit glyph ROM read path. It packs an incoming byte stream into DATA_WIDTH-bit words and writes them sequentially into a 2**ADDR_WIDTH-deep RAM. This lets the glyph table be reloaded at run time, for example from a UART bridge, instead of relying only on the init file. It sits between the byte source and the RAM write port and raises done when the whole table is written.

Parameters:
ADDR_WIDTH, 10, RAM address width; the table depth is 2**ADDR_WIDTH words.
DATA_WIDTH, 24, word width; must be a multiple of 8.
BPW, DATA_WIDTH/8, bytes per word; localparam, derived from DATA_WIDTH.

Ports:
clk  in  1  clock; all logic on posedge clk.
tb_rst  in  1  asynchronous, active-high reset.
start  in  1  single-cycle pulse that begins a load; ignored unless in IDLE or DONE.
s_byte  in  8  stream byte.
s_valid  in  1  s_byte is valid.
s_ready  out  1  loader accepts a byte this cycle.
wr_en  out  1  RAM write strobe.
wr_addr  out  ADDR_WIDTH  RAM write address.
wr_data  out  DATA_WIDTH  RAM write data.
rd_addr  out  ADDR_WIDTH  RAM read address; used only by the verify feature, otherwise held at 0.
rd_data  in  DATA_WIDTH  RAM read data; valid 1 cycle after rd_addr (unregistered output).
busy  out  1  high in LOAD or VERIFY.
done  out  1  high in DONE; held until the next start.
chk_err  out  1  verify mismatch flag; held until the next start.

Behaviour:
- Reset values: all outputs 0 and the state is IDLE. Reset asserted mid-operation aborts immediately, and a partial word is discarded.
- FSM states: IDLE, LOAD, VERIFY, DONE.
  - IDLE or DONE, on start: go to LOAD. Clear the word address, byte count, checksum, done and chk_err.
  - LOAD, after the last word is written: go to VERIFY if the feature is enabled, otherwise DONE.
  - VERIFY, after the last compare: go to DONE.
- Handshake:
  - s_ready = (state == LOAD) && !wr_en.
  - A byte is accepted when s_valid && s_ready.
  - s_valid low simply stalls; there is no timeout.
- Packing, big-endian: the first byte of a word goes to bits [DATA_WIDTH-1:DATA_WIDTH-8].
- Write timing:
  - When byte BPW-1 is accepted in cycle N, wr_en is high in cycle N+1 for exactly 1 cycle.
  - In that cycle wr_addr is the current word address and wr_data is the assembled word.
  - s_ready is low in cycle N+1, so the maximum rate is BPW+1 cycles per word.
- Address:
  - The word address increments after each write.
  - The write at address 2**ADDR_WIDTH-1 is the last one; the address wraps to 0 with no further write.
- Checksum: a 32-bit modular sum of the zero-extended written words, accumulated during LOAD.
- Simultaneous events:
  - start in LOAD or VERIFY is ignored.
  - start in the same cycle as reset release is ignored.
- wr_en is never asserted outside LOAD.

Optional Feature:
Macro NUM_RAM_LOADER_VERIFY_EN.
- Defined:
  - After LOAD, VERIFY sweeps rd_addr from 0 to 2**ADDR_WIDTH-1, one address per cycle.
  - rd_data is summed with a 1-cycle alignment.
  - One cycle after the last address, the read sum is compared to the load checksum. On mismatch chk_err goes to 1, then the FSM enters DONE.
  - Verify latency is 2**ADDR_WIDTH+1 cycles.
- Not defined:
  - LOAD goes directly to DONE.
  - The VERIFY state, read sum and compare logic are not synthesized.
  - rd_addr is tied to 0 and chk_err to 0.

Decomposition:
- Shared package num_pkg: the state enum, the NUM_ADDR_WIDTH=10 and NUM_DATA_WIDTH=24 constants, and the checksum width CHK_W=32.
- One natural sub-module, num_byte_packer: byte counter plus shift register, emitting word and word_valid.
- The FSM, address counter and checksum stay in the top level.

Test Plan:
- Reset mid-LOAD (after 5 bytes) -> all outputs 0, busy=0; a new start restarts at wr_addr 0 with the byte count cleared.
- Feed bytes 0x12,0x34,0x56 with s_valid held high -> one wr_en pulse, wr_addr=0, wr_data=0x123456, s_ready low for exactly that cycle.
- Full load of 3072 bytes into a RAM model with continuous s_valid -> 1024 writes, last wr_addr=0x3FF, done=1 at cycle 4096 after start plus 1 (1024 words × 4 cycles per word), no extra write.
- Random s_valid gaps (30% idle) -> RAM contents identical to the stream; wr_en count equals 1024.
- With VERIFY_EN and a clean RAM model -> chk_err=0, done 1025 cycles after the last write. Corrupt address 0x200 in the model -> chk_err=1.
- start pulsed while busy -> ignored, address sequence uninterrupted; start in DONE -> done and chk_err cleared, new load begins.

Source files
------------

// File: rtl/num_pkg.sv
// num_pkg: shared state encoding and default widths for the glyph RAM loader.
package num_pkg;
  localparam int NUM_ADDR_WIDTH = 10;
  localparam int NUM_DATA_WIDTH = 24;
  localparam int CHK_W = 32;
  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;
endpackage

// File: rtl/num_byte_packer.sv
// num_byte_packer: packs accepted bytes big-endian into words; word_valid pulses the cycle after the last byte.
module num_byte_packer #(
  parameter int DATA_WIDTH = 24,
  parameter int BPW = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [7:0]            in_byte,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_valid
);
  localparam int CW = BPW > 1 ? $clog2(BPW) : 1;
  logic [CW-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_word;
  logic r_valid;
  logic w_last;
  assign w_last = r_cnt == CW'(BPW - 1);
  assign word = r_word;
  assign word_valid = r_valid;
  always_ff @(posedge clk or posedge tb_rst)
    if (tb_rst) begin
      r_cnt <= '0;
      r_word <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid && w_last;
      if (clr) r_cnt <= '0;
      else if (in_valid) begin
        r_word <= (r_word << 8) | DATA_WIDTH'(in_byte);
        r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      end
    end
endmodule

// File: rtl/num_ram_loader.sv
// num_ram_loader: streams bytes into a glyph RAM word by word and raises done when the table is full.
// Optional read-back checksum verify pass enabled by NUM_RAM_LOADER_VERIFY_EN.
module num_ram_loader
  import num_pkg::*;
#(
  parameter int ADDR_WIDTH = NUM_ADDR_WIDTH,
  parameter int DATA_WIDTH = NUM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  start,
  input  logic [7:0]            s_byte,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  chk_err
);
  localparam int BPW = DATA_WIDTH / 8;
`ifdef NUM_RAM_LOADER_VERIFY_EN
  localparam state_t S_POST = VERIFY;
`else
  localparam state_t S_POST = DONE;
`endif
  state_t r_state;
  logic r_armed;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CHK_W-1:0] r_sum;
  logic w_go;
  assign w_go = start && r_armed && (r_state == IDLE || r_state == DONE);
  assign s_ready = r_state == LOAD && !wr_en;
  assign busy = r_state == LOAD || r_state == VERIFY;
  assign done = r_state == DONE;
  assign wr_addr = r_addr;
  num_byte_packer #(.DATA_WIDTH(DATA_WIDTH), .BPW(BPW)) u_packer (
    .clk(clk),
    .tb_rst(tb_rst),
    .clr(w_go),
    .in_valid(s_valid && s_ready),
    .in_byte(s_byte),
    .word(wr_data),
    .word_valid(wr_en)
  );
`ifdef NUM_RAM_LOADER_VERIFY_EN
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [CHK_W-1:0] r_rd_sum;
  logic r_rd_vld, r_swept, r_chk_err;
  logic [CHK_W-1:0] w_rd_sum;
  // rd_data lags rd_addr by one cycle, so the first VERIFY cycle carries no data
  assign w_rd_sum = r_rd_sum + (r_rd_vld ? CHK_W'(rd_data) : '0);
  assign rd_addr = r_rd_addr;
  assign chk_err = r_chk_err;
`else
  logic w_unused;
  assign w_unused = ^{rd_data, r_sum};
  assign rd_addr = '0;
  assign chk_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge tb_rst)
    if (tb_rst) begin
      r_state <= IDLE;
      r_armed <= 1'b0;
      r_addr <= '0;
      r_sum <= '0;
`ifdef NUM_RAM_LOADER_VERIFY_EN
      r_rd_addr <= '0;
      r_rd_sum <= '0;
      r_rd_vld <= 1'b0;
      r_swept <= 1'b0;
      r_chk_err <= 1'b0;
`endif
    end else begin
      r_armed <= 1'b1;
      if (w_go) begin
        r_state <= LOAD;
        r_addr <= '0;
        r_sum <= '0;
`ifdef NUM_RAM_LOADER_VERIFY_EN
        r_rd_addr <= '0;
        r_rd_sum <= '0;
        r_rd_vld <= 1'b0;
        r_swept <= 1'b0;
        r_chk_err <= 1'b0;
`endif
      end else if (r_state == LOAD && wr_en) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
        r_sum <= r_sum + CHK_W'(wr_data);
        if (&r_addr) r_state <= S_POST;
      end
`ifdef NUM_RAM_LOADER_VERIFY_EN
      else if (r_state == VERIFY) begin
        r_rd_addr <= r_swept ? '0 : r_rd_addr + ADDR_WIDTH'(1);
        r_rd_vld <= 1'b1;
        r_swept <= &r_rd_addr;
        r_rd_sum <= w_rd_sum;
        if (r_swept) begin
          r_chk_err <= w_rd_sum != r_sum;
          r_state <= DONE;
        end
      end
`endif
    end
endmodule

// File: tb/tb_num_ram_loader.sv
// tb_num_ram_loader: directed bench with a RAM model for num_ram_loader.
module tb_num_ram_loader;
`ifdef NUM_RAM_LOADER_VERIFY_EN
  localparam int VLAT = 1025;
`else
  localparam int VLAT = 0;
`endif
  logic clk, tb_rst, start, s_valid, s_ready, wr_en, busy, done, chk_err;
  logic [7:0] s_byte;
  logic [9:0] wr_addr, rd_addr, last_addr;
  logic [23:0] wr_data, rd_data;
  logic [23:0] mem [0:1023];
  logic mon_clr, corrupt;
  int cyc, wcount, seq_err, last_w, s_cyc;
  int checks, failures;

  num_ram_loader dut (
    .clk(clk), .tb_rst(tb_rst), .start(start), .s_byte(s_byte), .s_valid(s_valid),
    .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .chk_err(chk_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_data <= mem[rd_addr] ^ ((corrupt && rd_addr == 10'h200) ? 24'h1 : 24'h0);
    if (mon_clr) begin
      wcount <= 0;
      seq_err <= 0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
      wcount <= wcount + 1;
      last_addr <= wr_addr;
      last_w <= cyc;
      if (wr_addr != 10'(wcount)) seq_err <= seq_err + 1;
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bval(input int i, input int salt);
    return 8'(i * 13 + salt + (i >> 8));
  endfunction

  task automatic put(input logic [7:0] b);
    bit ok;
    ok = 0;
    s_byte = b;
    s_valid = 1;
    for (int g = 0; g < 100 && !ok; g++) begin
      ok = s_ready;
      tick;
    end
    chk("put_accept", 32'(ok), 1);
  endtask

  task automatic load(input int salt, input bit gaps, input bit pulse, input bit timed, input bit exp_err);
    int idx, g, d, errs;
    logic [23:0] ew;
    mon_clr = 1;
    start = 1;
    s_cyc = cyc;
    tick;
    start = 0;
    mon_clr = 0;
    chk("go_busy", 32'(busy), 1);
    chk("go_done_clr", 32'(done), 0);
    chk("go_err_clr", 32'(chk_err), 0);
    idx = 0;
    g = 0;
    while (idx < 3072 && g < 20000) begin
      s_valid = gaps ? ($urandom_range(0, 9) >= 3) : 1'b1;
      start = pulse && (idx % 500 == 250);
      s_byte = bval(idx, salt);
      if (s_valid && s_ready) idx++;
      tick;
      g++;
    end
    s_valid = 0;
    start = 0;
    g = 0;
    while (!done && g < 3000) begin
      tick;
      g++;
    end
    d = cyc - s_cyc;
    chk("load_done", 32'(done), 1);
    if (timed) begin
      chk("done_cycle", 32'(d), 32'(4097 + VLAT));
      chk("last_write_cycle", 32'(last_w - s_cyc), 4096);
    end
    chk("write_count", 32'(wcount), 1024);
    chk("last_addr", 32'(last_addr), 32'h3FF);
    chk("addr_sequence", 32'(seq_err), 0);
    chk("done_busy", 32'(busy), 0);
    chk("chk_err", 32'(chk_err), 32'(exp_err));
    errs = 0;
    for (int k = 0; k < 1024; k++) begin
      ew = {bval(3 * k, salt), bval(3 * k + 1, salt), bval(3 * k + 2, salt)};
      if (mem[k] !== ew) errs++;
    end
    chk("ram_contents", 32'(errs), 0);
    repeat (5) tick;
    chk("no_extra_write", 32'(wcount), 1024);
    chk("addr_wrapped", 32'(wr_addr), 0);
    chk("done_held", 32'(done), 1);
    chk("rd_addr_idle", 32'(rd_addr), 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    tb_rst = 1;
    start = 0;
    s_valid = 0;
    s_byte = 0;
    mon_clr = 1;
    corrupt = 0;
    repeat (2) tick;
    chk("rst_flags", {27'b0, wr_en, s_ready, busy, done, chk_err}, 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    tb_rst = 0;
    start = 1;
    tick;
    start = 0;
    chk("start_at_release", 32'(busy), 0);
    start = 1;
    tick;
    start = 0;
    chk("start_busy", 32'(busy), 1);
    for (int i = 0; i < 5; i++) put(8'(8'hA0 + i));
    s_valid = 0;
    tb_rst = 1;
    tick;
    chk("midrst_flags", {27'b0, wr_en, s_ready, busy, done, chk_err}, 0);
    chk("midrst_wr_addr", 32'(wr_addr), 0);
    chk("midrst_wr_data", 32'(wr_data), 0);
    tb_rst = 0;
    tick;
    start = 1;
    tick;
    start = 0;
    mon_clr = 0;
    put(8'h12);
    put(8'h34);
    put(8'h56);
    s_valid = 0;
    chk("word_wr_en", 32'(wr_en), 1);
    chk("word_wr_addr", 32'(wr_addr), 0);
    chk("word_wr_data", 32'(wr_data), 32'h123456);
    chk("word_s_ready_low", 32'(s_ready), 0);
    tick;
    chk("word_wr_en_pulse", 32'(wr_en), 0);
    chk("word_s_ready_back", 32'(s_ready), 1);
    chk("word_count", 32'(wcount), 1);
    chk("word_next_addr", 32'(wr_addr), 1);
    tb_rst = 1;
    tick;
    tb_rst = 0;
    tick;
    load(0, 1'b0, 1'b0, 1'b1, 1'b0);
    load(77, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef NUM_RAM_LOADER_VERIFY_EN
    corrupt = 1;
    load(5, 1'b0, 1'b0, 1'b1, 1'b1);
    corrupt = 0;
    load(9, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
